// File: rtl/div_byte_host.sv
// div_byte_host: host-side initiator for the byte-serial divider core.
// Serializes a 32/32 dividend/divisor pair into 8 push-strobed bytes, then
// gathers the divider's 8-byte pull-framed reply into quotient/remainder.
// Optional feature: define DIVHOST_TIMEOUT_EN to bound the wait for pull_in
// to TIMEOUT_CYC cycles (otherwise rsp_timeout is tied low).
module div_byte_host #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned GAP_CYC     = 1,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sign,
  input  logic [31:0] cmd_dividend,
  input  logic [31:0] cmd_divisor,
  output logic [7:0]  byte_out,
  output logic        push_out,
  output logic        sign_out,
  input  logic [7:0]  byte_in,
  input  logic        pull_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_remainder,
  output logic        rsp_timeout
);

  // One shared cycle counter serves SETUP, GAP and the WAIT timeout.
  localparam int unsigned MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int unsigned CNT_MAX = (MAX_SG > TIMEOUT_CYC) ? MAX_SG : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_PUSH    = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COLLECT = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       col_q, col_d;
  logic [55:0]      shreg_q, shreg_d;
  logic [63:0]      res_q, res_d;
  logic [7:0]       byte_q, byte_d;
  logic             sign_q, sign_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             push_q, push_d;
  logic             valid_q, valid_d;
  logic             adv;
`ifdef DIVHOST_TIMEOUT_EN
  logic             to_q, to_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    col_d   = col_q;
    shreg_d = shreg_q;
    res_d   = res_q;
    byte_d  = byte_q;
    sign_d  = sign_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    adv     = 1'b0;
`ifdef DIVHOST_TIMEOUT_EN
    to_d    = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = S_SETUP;
          byte_d  = cmd_dividend[31:24];
          shreg_d = {cmd_dividend[23:0], cmd_divisor};
          idx_d   = 3'd0;
          cnt_d   = '0;
          sign_d  = cmd_sign;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = S_PUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PUSH: begin
        if (GAP_CYC == 0) begin
          adv = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (pull_in) begin
          state_d = S_COLLECT;
          res_d   = {56'd0, byte_in};
          col_d   = 3'd1;
          cnt_d   = '0;
        end
`ifdef DIVHOST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
          quot_d  = 32'hFFFF_FFFF;
          rem_d   = 32'hFFFF_FFFF;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_COLLECT: begin
        res_d[{col_q, 3'b000} +: 8] = byte_in;
        col_d = col_q + 3'd1;
        if (col_q == 3'd7) begin
          state_d = S_RESP;
          quot_d  = res_d[63:32];
          rem_d   = res_d[31:0];
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
`ifdef DIVHOST_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next byte, or hand over to the reply wait after byte 7.
    if (adv) begin
      if (idx_q != 3'd7) begin
        state_d = S_SETUP;
        idx_d   = idx_q + 3'd1;
        byte_d  = shreg_q[55:48];
        shreg_d = {shreg_q[47:0], 8'h00};
      end else begin
        state_d = S_WAIT;
      end
    end

    ready_d = (state_d == S_IDLE);
    push_d  = (state_d == S_PUSH);
    valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      col_q   <= 3'd0;
      shreg_q <= '0;
      res_q   <= '0;
      byte_q  <= 8'h00;
      sign_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      push_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef DIVHOST_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      shreg_q <= shreg_d;
      res_q   <= res_d;
      byte_q  <= byte_d;
      sign_q  <= sign_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      push_q  <= push_d;
      valid_q <= valid_d;
`ifdef DIVHOST_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign cmd_ready     = ready_q;
  assign byte_out      = byte_q;
  assign push_out      = push_q;
  assign sign_out      = sign_q;
  assign rsp_valid     = valid_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
`ifdef DIVHOST_TIMEOUT_EN
  assign rsp_timeout   = to_q;
`else
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_div_byte_host.sv
// tb_div_byte_host: directed bench for div_byte_host with a scripted divider reply.
module tb_div_byte_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_sign;
  logic [31:0] cmd_dividend, cmd_divisor;
  logic [7:0]  byte_out, byte_in;
  logic        push_out, sign_out, pull_in;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_quotient, rsp_remainder;

  int checks   = 0;
  int failures = 0;

  div_byte_host #(.SETUP_CYC(1), .GAP_CYC(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sign(cmd_sign),
    .cmd_dividend(cmd_dividend), .cmd_divisor(cmd_divisor),
    .byte_out(byte_out), .push_out(push_out), .sign_out(sign_out),
    .byte_in(byte_in), .pull_in(pull_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue a command and check each pushed byte against {dvd,dvs}, MSB byte first.
  // Pushes arrive at negedges 1+3k after the accepting edge. Returns with last push seen.
  task automatic send_cmd(input string nm, input logic sgn, input logic [31:0] dvd,
                          input logic [31:0] dvs, input bit stray, input int stop_at);
    logic [63:0] pair;
    int n;
    pair = {dvd, dvs};
    @(negedge clk);
    check_eq({nm, ".idle_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_sign = sgn; cmd_dividend = dvd; cmd_divisor = dvs;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq({nm, ".busy"}, 64'(cmd_ready), 64'd0);
    pull_in = stray; byte_in = 8'hAA;
    n = 0;
    for (int c = 1; c < 60 && n < 8 && n != stop_at; c++) begin
      @(negedge clk);
      pull_in = stray && (c == 1);
      if (push_out) begin
        check_eq($sformatf("%s.byte%0d", nm, n), 64'(byte_out), 64'(pair[63 - 8*n -: 8]));
        check_eq($sformatf("%s.tpush%0d", nm, n), 64'(c), 64'(1 + 3*n));
        n++;
      end
    end
    pull_in = 1'b0; byte_in = 8'h00;
    if (stop_at < 0) check_eq({nm, ".npush"}, 64'(n), 64'd8);
  endtask

  // Full transaction: command, 8-byte reply, response check, optional back-pressure.
  task automatic do_txn(input string nm, input logic sgn, input logic [31:0] dvd,
                        input logic [31:0] dvs, input logic [63:0] rep,
                        input bit stray, input bit extra, input int hold);
    bit seen;
    send_cmd(nm, sgn, dvd, dvs, stray, -1);
    @(negedge clk);
    @(negedge clk);
    check_eq({nm, ".wait_busy"}, 64'(cmd_ready), 64'd0);
    pull_in = 1'b1; byte_in = rep[7:0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      byte_in = rep[8*i +: 8];
      pull_in = extra && (i == 3);
    end
    @(negedge clk);
    pull_in = 1'b0; byte_in = 8'h00;
    check_eq({nm, ".rsp_lat"}, 64'(rsp_valid), 64'd1);
    seen = rsp_valid;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check_eq({nm, ".quot"}, 64'(rsp_quotient), 64'(rep[63:32]));
    check_eq({nm, ".rem"}, 64'(rsp_remainder), 64'(rep[31:0]));
    check_eq({nm, ".sign"}, 64'(sign_out), 64'(sgn));
    check_eq({nm, ".tmo"}, 64'(rsp_timeout), 64'd0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_sign = 1'b0;
      cmd_dividend = 32'h0000_0055; cmd_divisor = 32'h0000_0005;
      @(negedge clk);
      check_eq($sformatf("%s.hold_v%0d", nm, h), 64'(rsp_valid), 64'd1);
      check_eq($sformatf("%s.hold_q%0d", nm, h), {rsp_quotient, rsp_remainder}, rep);
      check_eq($sformatf("%s.hold_rdy%0d", nm, h), 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check_eq({nm, ".done_v"}, 64'(rsp_valid), 64'd0);
    check_eq({nm, ".done_rdy"}, 64'(cmd_ready), 64'd1);
    check_eq({nm, ".sign_kept"}, 64'(sign_out), 64'(sgn));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_sign = 1'b0; cmd_dividend = '0; cmd_divisor = '0;
    byte_in = 8'h00; pull_in = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.ready", 64'(cmd_ready), 64'd1);
    check_eq("rst.push", 64'(push_out), 64'd0);
    check_eq("rst.byte", 64'(byte_out), 64'd0);
    check_eq("rst.sign", 64'(sign_out), 64'd0);
    check_eq("rst.valid", 64'(rsp_valid), 64'd0);
    check_eq("rst.data", {rsp_quotient, rsp_remainder}, 64'd0);
    check_eq("rst.tmo", 64'(rsp_timeout), 64'd0);
    rst = 1'b0;

    // 100/7 unsigned: q=14, r=2
    do_txn("u100_7", 1'b0, 32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002}, 1'b0, 1'b0, 0);
    // -100/7 sign-magnitude, result passed raw
    do_txn("s100_7", 1'b1, 32'h8000_0064, 32'h0000_0007,
           {32'h8000_000E, 32'h8000_0002}, 1'b0, 1'b0, 0);
    // 1000/33 = 30 r 10, response held 10 cycles with a competing command
    do_txn("bp", 1'b0, 32'd1000, 32'd33, {32'd30, 32'd10}, 1'b0, 1'b0, 10);
    // stray pull_in during SETUP/PUSH and a second pull_in inside COLLECT
    do_txn("stray", 1'b0, 32'h1234_5678, 32'h0000_0100,
           {32'h0012_3456, 32'h0000_0078}, 1'b1, 1'b1, 0);

    // reset during byte 5 aborts; fresh command restarts at dividend[31:24]
    send_cmd("abort", 1'b1, 32'hCAFE_F00D, 32'h0102_0304, 1'b0, 6);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort.push", 64'(push_out), 64'd0);
    check_eq("abort.ready", 64'(cmd_ready), 64'd1);
    check_eq("abort.sign", 64'(sign_out), 64'd0);
    check_eq("abort.valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    do_txn("div0", 1'b0, 32'hDEAD_BEEF, 32'h0000_0000,
           {32'hFFFF_FFFF, 32'hDEAD_BEEF}, 1'b0, 1'b0, 0);

`ifdef DIVHOST_TIMEOUT_EN
    begin
      int cyc;
      bit seen;
      send_cmd("tmo", 1'b0, 32'd9, 32'd3, 1'b0, -1);
      // last push at negedge 22, WAIT entered at edge 24, timeout fires at edge 40
      cyc = 0; seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        @(negedge clk);
        cyc++;
        seen = rsp_valid;
      end
      check_eq("tmo.lat", 64'(cyc), 64'd18);
      check_eq("tmo.flag", 64'(rsp_timeout), 64'd1);
      check_eq("tmo.data", {rsp_quotient, rsp_remainder}, 64'hFFFF_FFFF_FFFF_FFFF);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("tmo.clr", 64'(rsp_timeout), 64'd0);
      check_eq("tmo.ready", 64'(cmd_ready), 64'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_byte_host.md
Name: div_byte_host

Overview:
- Host-side initiator for the byte-serial divider core interface.
- Accepts one 32-bit dividend/divisor pair with a signed/unsigned flag over a valid/ready command port.
- Serializes the pair into 8 push-strobed bytes toward the divider, then deserializes the divider's 8-byte pull-framed result into a 32-bit quotient and 32-bit remainder.
- Sits between a bus-side master (CPU/test sequencer) and the divider core's data_in_in/push_in/data_out_out/pull_out pins.

Parameters:
- SETUP_CYC, 1, cycles the byte is held on byte_out before push_out asserts (min 1)
- GAP_CYC, 1, idle cycles after each push_out pulse before the next byte is driven (min 0)
- TIMEOUT_CYC, 4096, max cycles waiting for pull_in after the last push (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_sign  in  1  0 unsigned, 1 signed (sign-magnitude)
- cmd_dividend  in  32  dividend
- cmd_divisor  in  32  divisor
- byte_out  out  8  byte to divider data input
- push_out  out  1  one-cycle strobe, byte_out valid
- sign_out  out  1  mode to divider, held for whole transaction
- byte_in  in  8  byte from divider data output
- pull_in  in  1  frame start strobe, byte_in carries result byte 0 in the same cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid&rsp_ready
- rsp_quotient  out  32  result bits [63:32]
- rsp_remainder  out  32  result bits [31:0]
- rsp_timeout  out  1  result invalid, divider did not answer

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; cmd_ready=1; push_out=0; byte_out=0; sign_out=0; rsp_valid=0; rsp_quotient=0; rsp_remainder=0; rsp_timeout=0; all counters 0. Reset mid-transaction aborts immediately with no partial response.
- States: IDLE -> SETUP -> PUSH -> GAP -> (SETUP | WAIT) -> COLLECT -> RESP -> IDLE.
- IDLE: cmd_ready=1. On handshake, latch {dividend,divisor} into a 64-bit shift register; byte index=0; sign_out<=cmd_sign; go to SETUP.
- Byte order on byte_out: dividend[31:24], [23:16], [15:8], [7:0], then divisor[31:24] ... [7:0].
- SETUP: byte_out=current byte for SETUP_CYC cycles -> PUSH.
- PUSH: push_out=1 for exactly one cycle with byte_out unchanged -> GAP.
- GAP: push_out=0 for GAP_CYC cycles (GAP_CYC=0 skips GAP). Then, if byte index<7, increment it and go to SETUP; else go to WAIT.
- Per-byte period = SETUP_CYC+1+GAP_CYC; defaults give 3 cycles/byte, 24 cycles from accept to WAIT.
- WAIT: pull_in=1 captures byte_in as byte 0 -> COLLECT with count=1.
- COLLECT: captures byte_in on each of the next 7 cycles unconditionally; pull_in is ignored here. Assembly: result[8k+7:8k]=byte k, LSB byte first. After byte 7 -> RESP.
- RESP: rsp_valid=1; rsp_quotient=result[63:32]; rsp_remainder=result[31:0]; outputs stable until rsp_ready, then -> IDLE.
- Data is passed raw. In signed mode the quotient sign is bit 31 of rsp_quotient and the remainder sign is bit 31 of rsp_remainder; no conversion is done here.
- pull_in outside WAIT/COLLECT is ignored and has no effect.
- sign_out holds its value through RESP and changes only on the next command accept.
- cmd_ready=0 in every state except IDLE.
- Divisor 0 is forwarded unchanged; the result is whatever the divider returns.

Optional Feature:
- DIVHOST_TIMEOUT_EN defined: a counter runs in WAIT. After TIMEOUT_CYC cycles with no pull_in, go to RESP with rsp_timeout=1 and quotient/remainder=32'hFFFFFFFF. rsp_timeout clears on the rsp handshake.
- Not defined: WAIT has no time limit and rsp_timeout is tied 0.

Test Plan:
- Unsigned 100/7, defaults: bytes 00,00,00,64,00,00,00,07 each pushed 3 cycles apart. Model replies pull_in with bytes 02,00,00,00,0E,00,00,00 -> rsp_quotient=14, rsp_remainder=2.
- Signed -100/7 (sign-magnitude 0x80000064, 0x00000007): sign_out=1 through RESP. Model reply -> quotient 0x8000000E, remainder 0x80000002 passed raw.
- Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, cmd_ready=0. Second cmd_valid during this time is not accepted until after the rsp handshake.
- Stray pull_in during SETUP/PUSH and a second pull_in inside COLLECT -> ignored; result assembled from the first frame only.
- rst=1 asserted during byte 5 -> next cycle push_out=0, cmd_ready=1; a fresh command restarts from dividend[31:24].
- DIVHOST_TIMEOUT_EN with TIMEOUT_CYC=16 and no pull_in -> rsp_valid rises 16 cycles after entering WAIT with rsp_timeout=1 and both results 0xFFFFFFFF.
